// File: rtl/rat_pipe_pkg.sv
// Shared types and control-vector constants for the RAT pipeline stage registers.
package rat_pipe_pkg;

    typedef struct packed {
        logic       PC_LD;
        logic       PC_INC;
        logic [1:0] PC_MUX_SEL;
        logic       SP_LD;
        logic       SP_INCR;
        logic       SP_DECR;
        logic       RF_WR;
        logic [1:0] RF_WR_SEL;
        logic       ALU_OPY_SEL;
        logic [3:0] ALU_SEL;
        logic       SCR_WE;
        logic       SCR_DATA_SEL;
        logic [1:0] SCR_ADDR_SEL;
        logic       FLG_C_SET;
        logic       FLG_C_CLR;
        logic       FLG_C_LD;
        logic       FLG_Z_LD;
        logic       FLG_LD_SEL;
        logic       FLG_SHAD_LD;
        logic       I_SET;
        logic       I_CLR;
        logic       IO_STRB;
        logic [3:0] BRANCH_TYPE;
        logic       RST;
    } ctrl_vec_t;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        JUMP_PEND = 1'b1
    } int_state_t;

    function automatic ctrl_vec_t mk_ctrl_nop();
        ctrl_vec_t c;
        c = '0;
        return c;
    endfunction

    // Push the return PC onto the stack: decrement SP, write scratch at SP-1.
    function automatic ctrl_vec_t mk_ctrl_int_push();
        ctrl_vec_t c;
        c              = '0;
        c.SP_DECR      = 1'b1;
        c.SCR_WE       = 1'b1;
        c.SCR_ADDR_SEL = 2'b11;
        c.SCR_DATA_SEL = 1'b1;
        return c;
    endfunction

    // Jump to the vector, mask interrupts and shadow the flags.
    function automatic ctrl_vec_t mk_ctrl_int_jump();
        ctrl_vec_t c;
        c             = '0;
        c.PC_LD       = 1'b1;
        c.PC_MUX_SEL  = 2'b10;
        c.I_CLR       = 1'b1;
        c.FLG_SHAD_LD = 1'b1;
        return c;
    endfunction

    localparam ctrl_vec_t CTRL_NOP      = mk_ctrl_nop();
    localparam ctrl_vec_t CTRL_INT_PUSH = mk_ctrl_int_push();
    localparam ctrl_vec_t CTRL_INT_JUMP = mk_ctrl_int_jump();

endpackage

// File: rtl/int_inject_fsm.sv
// Two-cycle interrupt injection sequencer: PUSH (return PC) then JUMP (vector),
// holding the upstream stage while it runs.
module int_inject_fsm
    import rat_pipe_pkg::*;
#(
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] INT_VEC_PC = 10'h3FF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            int_req,
    input  logic [PC_W-1:0] in_pc,
    output logic            up_stall,
    output logic            inj_act,
    output ctrl_vec_t       inj_ctrl,
    output logic [PC_W-1:0] inj_pc,
    output logic [PC_W-1:0] inj_dest_addr
);

    int_state_t      state_r;
    int_state_t      state_nxt_s;
    logic [PC_W-1:0] ret_pc_r;
    logic [PC_W-1:0] ret_pc_nxt_s;

    // State and return-PC registers; stall freezes the sequence in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ret_pc_r <= {PC_W{1'b0}};
        end else if (stall) begin
            state_r  <= state_r;
            ret_pc_r <= ret_pc_r;
        end else begin
            state_r  <= state_nxt_s;
            ret_pc_r <= ret_pc_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s  = state_r;
        ret_pc_nxt_s = ret_pc_r;
        case (state_r)
            IDLE: begin
                if (int_req) begin
                    state_nxt_s  = JUMP_PEND;
                    ret_pc_nxt_s = in_pc;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            JUMP_PEND: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: injected control/address fields and upstream hold.
    always_comb begin
        inj_act       = 1'b0;
        inj_ctrl      = CTRL_NOP;
        inj_pc        = {PC_W{1'b0}};
        inj_dest_addr = {PC_W{1'b0}};
        up_stall      = stall;
        case (state_r)
            IDLE: begin
                if (int_req) begin
                    inj_act  = 1'b1;
                    inj_ctrl = CTRL_INT_PUSH;
                    inj_pc   = in_pc;
                    up_stall = 1'b1;
                end else begin
                    inj_act  = 1'b0;
                end
            end
            JUMP_PEND: begin
                inj_act       = 1'b1;
                inj_ctrl      = CTRL_INT_JUMP;
                inj_pc        = ret_pc_r;
                inj_dest_addr = INT_VEC_PC;
                up_stall      = 1'b1;
            end
            default: begin
                inj_act = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_stage_ctrl_reg.sv
// Inter-stage pipeline register with stall, flush-to-bubble, interrupt
// injection and a saturating flush-bubble counter.
module pipe_stage_ctrl_reg
    import rat_pipe_pkg::*;
#(
    parameter int              IR_W       = 18,
    parameter int              DATA_W     = 8,
    parameter int              WB_ADDR_W  = 5,
    parameter int              PC_W       = 10,
    parameter logic [PC_W-1:0] INT_VEC_PC = 10'h3FF,
    parameter int              BUB_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 int_req,
    output logic                 up_stall,
    input  logic                 in_valid,
    input  ctrl_vec_t            in_ctrl,
    input  logic [IR_W-1:0]      in_ir,
    input  logic [DATA_W-1:0]    in_dx,
    input  logic [DATA_W-1:0]    in_dy,
    input  logic [WB_ADDR_W-1:0] in_wb_addr,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PC_W-1:0]      in_dest_addr,
    output logic                 out_valid,
    output ctrl_vec_t            out_ctrl,
    output logic [IR_W-1:0]      out_ir,
    output logic [DATA_W-1:0]    out_dx,
    output logic [DATA_W-1:0]    out_dy,
    output logic [WB_ADDR_W-1:0] out_wb_addr,
    output logic [PC_W-1:0]      out_pc,
    output logic [PC_W-1:0]      out_dest_addr,
    output logic [BUB_CNT_W-1:0] bubble_cnt
);

    localparam logic [BUB_CNT_W-1:0] BUB_MAX = {BUB_CNT_W{1'b1}};
    localparam logic [BUB_CNT_W-1:0] BUB_ONE = {{(BUB_CNT_W-1){1'b0}}, 1'b1};

    logic            inj_act_s;
    ctrl_vec_t       inj_ctrl_s;
    logic [PC_W-1:0] inj_pc_s;
    logic [PC_W-1:0] inj_dest_s;

    logic                 valid_r,  valid_nxt_s;
    ctrl_vec_t            ctrl_r,   ctrl_nxt_s;
    logic [IR_W-1:0]      ir_r,     ir_nxt_s;
    logic [DATA_W-1:0]    dx_r,     dx_nxt_s;
    logic [DATA_W-1:0]    dy_r,     dy_nxt_s;
    logic [WB_ADDR_W-1:0] wb_r,     wb_nxt_s;
    logic [PC_W-1:0]      pc_r,     pc_nxt_s;
    logic [PC_W-1:0]      dest_r,   dest_nxt_s;
    logic [BUB_CNT_W-1:0] bub_r,    bub_nxt_s;

    int_inject_fsm #(
        .PC_W       (PC_W),
        .INT_VEC_PC (INT_VEC_PC)
    ) u_int_fsm (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .int_req       (int_req),
        .in_pc         (in_pc),
        .up_stall      (up_stall),
        .inj_act       (inj_act_s),
        .inj_ctrl      (inj_ctrl_s),
        .inj_pc        (inj_pc_s),
        .inj_dest_addr (inj_dest_s)
    );

    // Next-value selection: stall > interrupt injection > flush > passthrough.
    always_comb begin
        valid_nxt_s = valid_r;
        ctrl_nxt_s  = ctrl_r;
        ir_nxt_s    = ir_r;
        dx_nxt_s    = dx_r;
        dy_nxt_s    = dy_r;
        wb_nxt_s    = wb_r;
        pc_nxt_s    = pc_r;
        dest_nxt_s  = dest_r;
        bub_nxt_s   = bub_r;
        if (stall) begin
            bub_nxt_s = bub_r;
        end else if (inj_act_s) begin
            valid_nxt_s = 1'b1;
            ctrl_nxt_s  = inj_ctrl_s;
            ir_nxt_s    = {IR_W{1'b0}};
            dx_nxt_s    = {DATA_W{1'b0}};
            dy_nxt_s    = {DATA_W{1'b0}};
            wb_nxt_s    = {WB_ADDR_W{1'b0}};
            pc_nxt_s    = inj_pc_s;
            dest_nxt_s  = inj_dest_s;
        end else if (flush) begin
            valid_nxt_s = 1'b0;
            ctrl_nxt_s  = CTRL_NOP;
            ir_nxt_s    = {IR_W{1'b0}};
            dx_nxt_s    = {DATA_W{1'b0}};
            dy_nxt_s    = {DATA_W{1'b0}};
            wb_nxt_s    = {WB_ADDR_W{1'b0}};
            pc_nxt_s    = {PC_W{1'b0}};
            dest_nxt_s  = {PC_W{1'b0}};
            if (bub_r != BUB_MAX) begin
                bub_nxt_s = bub_r + BUB_ONE;
            end else begin
                bub_nxt_s = bub_r;
            end
        end else begin
            valid_nxt_s = in_valid;
            ctrl_nxt_s  = in_valid ? in_ctrl : CTRL_NOP;
            ir_nxt_s    = in_ir;
            dx_nxt_s    = in_dx;
            dy_nxt_s    = in_dy;
            wb_nxt_s    = in_wb_addr;
            pc_nxt_s    = in_pc;
            dest_nxt_s  = in_dest_addr;
        end
    end

    // Stage registers and bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            ctrl_r  <= CTRL_NOP;
            ir_r    <= {IR_W{1'b0}};
            dx_r    <= {DATA_W{1'b0}};
            dy_r    <= {DATA_W{1'b0}};
            wb_r    <= {WB_ADDR_W{1'b0}};
            pc_r    <= {PC_W{1'b0}};
            dest_r  <= {PC_W{1'b0}};
            bub_r   <= {BUB_CNT_W{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
            ir_r    <= ir_nxt_s;
            dx_r    <= dx_nxt_s;
            dy_r    <= dy_nxt_s;
            wb_r    <= wb_nxt_s;
            pc_r    <= pc_nxt_s;
            dest_r  <= dest_nxt_s;
            bub_r   <= bub_nxt_s;
        end
    end

    assign out_valid     = valid_r;
    assign out_ctrl      = ctrl_r;
    assign out_ir        = ir_r;
    assign out_dx        = dx_r;
    assign out_dy        = dy_r;
    assign out_wb_addr   = wb_r;
    assign out_pc        = pc_r;
    assign out_dest_addr = dest_r;
    assign bubble_cnt    = bub_r;

endmodule

// File: tb/tb_pipe_stage_ctrl_reg.sv
// Directed bench for pipe_stage_ctrl_reg: vector table plus interrupt/reset/saturation sequences.
module tb_pipe_stage_ctrl_reg;
    import rat_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, flush, int_req, up_stall, in_valid;
    ctrl_vec_t   in_ctrl;
    logic [17:0] in_ir;
    logic [7:0]  in_dx, in_dy;
    logic [4:0]  in_wb_addr;
    logic [9:0]  in_pc, in_dest_addr;
    logic        out_valid;
    ctrl_vec_t   out_ctrl;
    logic [17:0] out_ir;
    logic [7:0]  out_dx, out_dy;
    logic [4:0]  out_wb_addr;
    logic [9:0]  out_pc, out_dest_addr;
    logic [15:0] bubble_cnt;

    logic        up_stall2, out_valid2;
    ctrl_vec_t   out_ctrl2;
    logic [17:0] out_ir2;
    logic [7:0]  out_dx2, out_dy2;
    logic [4:0]  out_wb_addr2;
    logic [9:0]  out_pc2, out_dest_addr2;
    logic [1:0]  bubble_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage_ctrl_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .int_req(int_req),
        .up_stall(up_stall), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_ir(in_ir),
        .in_dx(in_dx), .in_dy(in_dy), .in_wb_addr(in_wb_addr), .in_pc(in_pc),
        .in_dest_addr(in_dest_addr), .out_valid(out_valid), .out_ctrl(out_ctrl),
        .out_ir(out_ir), .out_dx(out_dx), .out_dy(out_dy), .out_wb_addr(out_wb_addr),
        .out_pc(out_pc), .out_dest_addr(out_dest_addr), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_ctrl_reg #(.BUB_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .int_req(int_req),
        .up_stall(up_stall2), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_ir(in_ir),
        .in_dx(in_dx), .in_dy(in_dy), .in_wb_addr(in_wb_addr), .in_pc(in_pc),
        .in_dest_addr(in_dest_addr), .out_valid(out_valid2), .out_ctrl(out_ctrl2),
        .out_ir(out_ir2), .out_dx(out_dx2), .out_dy(out_dy2), .out_wb_addr(out_wb_addr2),
        .out_pc(out_pc2), .out_dest_addr(out_dest_addr2), .bubble_cnt(bubble_cnt2)
    );

    typedef struct {
        logic r, s, f, i, v;
        ctrl_vec_t c;
        logic [17:0] ir;
        logic [7:0]  dx, dy;
        logic [4:0]  wb;
        logic [9:0]  pc, dest;
        logic        e_v;
        ctrl_vec_t   e_c;
        logic [17:0] e_ir;
        logic [7:0]  e_dx, e_dy;
        logic [4:0]  e_wb;
        logic [9:0]  e_pc, e_dest;
        logic [15:0] e_bub;
    } vec_t;

    vec_t vecs[13];
    ctrl_vec_t ca, cb, nop_c, push_c, jump_c;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic i,
                         input logic v, input ctrl_vec_t c, input logic [9:0] pc);
        rst = r; stall = s; flush = f; int_req = i; in_valid = v; in_ctrl = c; in_pc = pc;
        in_ir = 18'h15555; in_dx = 8'h55; in_dy = 8'hAA; in_wb_addr = 5'h15; in_dest_addr = 10'h2D2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input ctrl_vec_t c,
                             input logic [9:0] pc, input logic [9:0] dest, input logic [15:0] bub);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".ctrl"},  64'(out_ctrl),  64'(c));
        check({tag, ".pc"},    64'(out_pc),    64'(pc));
        check({tag, ".dest"},  64'(out_dest_addr), 64'(dest));
        check({tag, ".bub"},   64'(bubble_cnt), 64'(bub));
    endtask

    initial begin
        nop_c = CTRL_NOP;
        push_c = '0; push_c.SP_DECR = 1'b1; push_c.SCR_WE = 1'b1;
        push_c.SCR_ADDR_SEL = 2'b11; push_c.SCR_DATA_SEL = 1'b1;
        jump_c = '0; jump_c.PC_LD = 1'b1; jump_c.PC_MUX_SEL = 2'b10;
        jump_c.I_CLR = 1'b1; jump_c.FLG_SHAD_LD = 1'b1;
        ca = '0; ca.ALU_SEL = 4'b0110; ca.RF_WR = 1'b1;
        cb = '0; cb.BRANCH_TYPE = 4'b1001; cb.IO_STRB = 1'b1; cb.RST = 1'b1;

        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, ca, 18'h2ABCD, 8'hA5, 8'h3C, 5'h1F, 10'h025, 10'h155,
                     1'b0, nop_c, 18'h0, 8'h00, 8'h00, 5'h00, 10'h000, 10'h000, 16'd0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, ca, 18'h2ABCD, 8'hA5, 8'h3C, 5'h1F, 10'h025, 10'h155,
                     1'b1, ca, 18'h2ABCD, 8'hA5, 8'h3C, 5'h1F, 10'h025, 10'h155, 16'd0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, ca, 18'h00123, 8'h11, 8'h22, 5'h03, 10'h026, 10'h000,
                     1'b0, nop_c, 18'h00123, 8'h11, 8'h22, 5'h03, 10'h026, 10'h000, 16'd0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, cb, 18'h3FFFF, 8'h5A, 8'hC3, 5'h0A, 10'h010, 10'h200,
                     1'b1, cb, 18'h3FFFF, 8'h5A, 8'hC3, 5'h0A, 10'h010, 10'h200, 16'd0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b1, ca, 18'h00001, 8'h01, 8'h01, 5'h01, 10'h011, 10'h001,
                     1'b1, cb, 18'h3FFFF, 8'h5A, 8'hC3, 5'h0A, 10'h010, 10'h200, 16'd0};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b1, ca, 18'h00002, 8'h02, 8'h02, 5'h02, 10'h012, 10'h002,
                     1'b1, cb, 18'h3FFFF, 8'h5A, 8'hC3, 5'h0A, 10'h010, 10'h200, 16'd0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b1, ca, 18'h00003, 8'h03, 8'h03, 5'h03, 10'h013, 10'h003,
                     1'b1, cb, 18'h3FFFF, 8'h5A, 8'hC3, 5'h0A, 10'h010, 10'h200, 16'd0};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b1, ca, 18'h2AAAA, 8'h77, 8'h66, 5'h07, 10'h050, 10'h0EE,
                     1'b0, nop_c, 18'h0, 8'h00, 8'h00, 5'h00, 10'h000, 10'h000, 16'd1};
        for (int k = 0; k < 4; k++) begin
            vecs[8+k] = vecs[7];
            vecs[8+k].pc = 10'h051 + 10'(k);
            vecs[8+k].e_bub = 16'd2 + 16'(k);
        end
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1, cb, 18'h01234, 8'h9C, 8'h4D, 5'h11, 10'h077, 10'h123,
                     1'b1, cb, 18'h01234, 8'h9C, 8'h4D, 5'h11, 10'h077, 10'h123, 16'd5};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nop_c, 10'h000);

        // Table-driven section.
        for (int n = 0; n < 13; n++) begin
            @(negedge clk);
            rst = vecs[n].r; stall = vecs[n].s; flush = vecs[n].f; int_req = vecs[n].i;
            in_valid = vecs[n].v; in_ctrl = vecs[n].c; in_ir = vecs[n].ir; in_dx = vecs[n].dx;
            in_dy = vecs[n].dy; in_wb_addr = vecs[n].wb; in_pc = vecs[n].pc; in_dest_addr = vecs[n].dest;
            step();
            check($sformatf("vec%0d.valid", n), 64'(out_valid), 64'(vecs[n].e_v));
            check($sformatf("vec%0d.ctrl", n),  64'(out_ctrl),  64'(vecs[n].e_c));
            check($sformatf("vec%0d.ir", n),    64'(out_ir),    64'(vecs[n].e_ir));
            check($sformatf("vec%0d.dx", n),    64'(out_dx),    64'(vecs[n].e_dx));
            check($sformatf("vec%0d.dy", n),    64'(out_dy),    64'(vecs[n].e_dy));
            check($sformatf("vec%0d.wb", n),    64'(out_wb_addr), 64'(vecs[n].e_wb));
            check($sformatf("vec%0d.pc", n),    64'(out_pc),    64'(vecs[n].e_pc));
            check($sformatf("vec%0d.dest", n),  64'(out_dest_addr), 64'(vecs[n].e_dest));
            check($sformatf("vec%0d.bub", n),   64'(bubble_cnt), 64'(vecs[n].e_bub));
        end

        // Interrupt accept with simultaneous flush: interrupt wins, no bubble counted.
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nop_c, 10'h000); step();
        check_out("rst0", 1'b0, nop_c, 10'h000, 10'h000, 16'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ca, 10'h040); #1;
        check("int.up_stall_accept", 64'(up_stall), 64'(1'b1));
        step();
        check_out("int.push", 1'b1, push_c, 10'h040, 10'h000, 16'd0);
        check("int.push.dx", 64'(out_dx), 64'(8'h00));
        check("int.push.ir", 64'(out_ir), 64'(18'h0));
        @(negedge clk); drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ca, 10'h041); #1;
        check("int.up_stall_pend", 64'(up_stall), 64'(1'b1));
        step();
        check_out("int.jump", 1'b1, jump_c, 10'h040, 10'h3FF, 16'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ca, 10'h042); #1;
        check("int.up_stall_done", 64'(up_stall), 64'(1'b0));
        step();
        check_out("int.after", 1'b1, ca, 10'h042, 10'h2D2, 16'd0);

        // Stall during JUMP_PEND holds PUSH outputs; JUMP follows once stall drops.
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ca, 10'h0A0); step();
        check_out("stj.push", 1'b1, push_c, 10'h0A0, 10'h000, 16'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ca, 10'h0A1 + 10'(k)); #1;
            check("stj.up_stall", 64'(up_stall), 64'(1'b1));
            step();
            check_out("stj.hold", 1'b1, push_c, 10'h0A0, 10'h000, 16'd0);
        end
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ca, 10'h0A3); step();
        check_out("stj.jump", 1'b1, jump_c, 10'h0A0, 10'h3FF, 16'd0);

        // Reset during JUMP_PEND abandons the interrupt.
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ca, 10'h0C0); step();
        check_out("rsj.push", 1'b1, push_c, 10'h0C0, 10'h000, 16'd0);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ca, 10'h0C1); step();
        check_out("rsj.rst", 1'b0, nop_c, 10'h000, 10'h000, 16'd0);
        @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ca, 10'h0C2); #1;
        check("rsj.up_stall", 64'(up_stall), 64'(1'b0));
        step();
        check_out("rsj.norm", 1'b1, ca, 10'h0C2, 10'h2D2, 16'd0);

        // Bubble-counter saturation on the 2-bit instance.
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nop_c, 10'h000); step();
        check("sat.rst", 64'(bubble_cnt2), 64'(2'd0));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ca, 10'h100); step();
            check($sformatf("sat.cnt16_%0d", k), 64'(bubble_cnt), 64'(k));
            check($sformatf("sat.cnt2_%0d", k), 64'(bubble_cnt2), 64'((k > 3) ? 3 : k));
            check($sformatf("sat.valid_%0d", k), 64'(out_valid2), 64'(1'b0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_ctrl_reg.md
Name: pipe_stage_ctrl_reg

Overview:
- Parametrised inter-stage pipeline register for the pipelined RAT core.
- Carries the decoded control vector plus instruction, operand, write-back address and PC fields from one stage to the next.
- Supports stall (hold), flush (bubble) and a two-cycle interrupt injection sequence (push return PC, then jump to vector) that holds upstream while it runs.
- Keeps a saturating count of flush bubbles for performance debug.

Parameters:
- IR_W, 18: instruction field width.
- DATA_W, 8: width of the DX/DY operand fields.
- WB_ADDR_W, 5: width of the write-back register address.
- PC_W, 10: width of the program counter and destination address.
- INT_VEC_PC, 10'h3FF: interrupt vector address loaded in the JUMP cycle.
- BUB_CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream hold; freezes all state
- flush  in  1  replace incoming instruction with a bubble
- int_req  in  1  interrupt request, level-sampled
- up_stall  out  1  combinational hold request to upstream stage
- in_valid  in  1  incoming instruction valid
- in_ctrl  in  ctrl_vec_t  decoded control vector
- in_ir  in  IR_W  instruction
- in_dx  in  DATA_W  operand X
- in_dy  in  DATA_W  operand Y
- in_wb_addr  in  WB_ADDR_W  write-back register address
- in_pc  in  PC_W  PC of incoming instruction
- in_dest_addr  in  PC_W  branch target
- out_valid, out_ctrl, out_ir, out_dx, out_dy, out_wb_addr, out_pc, out_dest_addr  out  as inputs  registered copies
- bubble_cnt  out  BUB_CNT_W  flush bubbles inserted, saturating

Behaviour:
- Clock and reset: single clock, clk; rst is synchronous and active-high. All registers update only on the rising edge of clk.
- Reset values: every out_* field is 0, out_ctrl = CTRL_NOP, out_valid = 0, bubble_cnt = 0, FSM = IDLE. A reset mid-sequence abandons the interrupt; the next cycle is IDLE.
- Update priority, highest first: rst > stall > interrupt FSM > flush > normal.
- stall=1: all outputs, the FSM and bubble_cnt hold their values.
- FSM states: IDLE, JUMP_PEND.
- IDLE with int_req=1 and stall=0 (interrupt accept):
  - Load CTRL_INT_PUSH: SP_DECR=1, SCR_WE=1, SCR_ADDR_SEL=2'b11, SCR_DATA_SEL=1; all other fields 0.
  - out_pc = in_pc (return address: the interrupted instruction is discarded and re-fetched).
  - out_valid = 1; other data fields 0.
  - Latch in_pc into ret_pc; go to JUMP_PEND.
- JUMP_PEND with stall=0:
  - Load CTRL_INT_JUMP: PC_LD=1, PC_MUX_SEL=2'b10, I_CLR=1, FLG_SHAD_LD=1; all other fields 0.
  - out_pc = ret_pc; out_dest_addr = INT_VEC_PC; out_valid = 1.
  - Return to IDLE.
- flush and int_req are ignored while in JUMP_PEND. Flush in the accept cycle is ignored because the interrupt wins.
- up_stall = stall | (state==JUMP_PEND) | (state==IDLE & int_req). Upstream therefore holds for exactly 2 unstalled cycles per interrupt.
- flush=1 with no interrupt action:
  - out_ctrl = CTRL_NOP, out_valid = 0, all data fields 0.
  - bubble_cnt += 1, saturating at all-ones.
- Normal operation: all data fields pass through. out_valid = in_valid; out_ctrl = in_valid ? in_ctrl : CTRL_NOP. An invalid input is not counted as a bubble.
- Latency: 1 cycle input to output. Interrupt sequence: 2 unstalled cycles.
- Multi-bit ctrl constants are true binary widths; no string literals.

Decomposition:
- Package rat_pipe_pkg holds:
  - ctrl_vec_t, a packed struct: PC_LD, PC_INC, PC_MUX_SEL[1:0], SP_LD, SP_INCR, SP_DECR, RF_WR, RF_WR_SEL[1:0], ALU_OPY_SEL, ALU_SEL[3:0], SCR_WE, SCR_DATA_SEL, SCR_ADDR_SEL[1:0], FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, IO_STRB, BRANCH_TYPE[3:0], RST.
  - Constants CTRL_NOP, CTRL_INT_PUSH, CTRL_INT_JUMP.
  - Enum int_state_t.
- Sub-module int_inject_fsm contains the state register, ret_pc latch, up_stall and the vector select.
- The top module holds the data and ctrl registers and the bubble counter.

Test Plan:
- Reset mid-op: drive traffic, assert rst one cycle → next edge out_valid=0, out_ctrl=CTRL_NOP, bubble_cnt=0, outputs 0.
- Passthrough: in_valid=1, in_pc=10'h025, in_dx=8'hA5, in_ctrl.ALU_SEL=4'b0110 → one cycle later same values; in_valid=0 → out_ctrl=CTRL_NOP.
- Stall: load in_pc=10'h010, then stall=1 for 3 cycles with in_pc changing → out_pc stays 10'h010, bubble_cnt unchanged.
- Flush and saturation: flush=1 for 5 cycles → bubble_cnt=5, out_valid=0 each cycle. With BUB_CNT_W=2, flush 6 cycles → bubble_cnt=3.
- Interrupt: in_pc=10'h040, int_req=1, flush=1 in the same cycle → cycle 1 CTRL_INT_PUSH, out_pc=10'h040; cycle 2 CTRL_INT_JUMP, out_dest_addr=10'h3FF; up_stall high for both cycles; bubble_cnt unchanged.
- Interrupt disturbed: stall=1 during JUMP_PEND for 2 cycles → PUSH outputs held, JUMP follows after stall drops. rst during JUMP_PEND → IDLE with no JUMP issued.
